pong_referee: RTL and testbench
===============================

PONG_REFEREE -- requirements
Module: pong_referee

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset; the ports are named clk and reset.
REQ-002 Parameter PADDLE_HEIGHT, default 4: paddle length in rows, legal range 1..8.
REQ-003 Parameter WIN_SCORE, default 9: score that ends the game, legal range 1..15.
REQ-004 Parameter HOLD_TICKS, default 8: number of isBallMoving pulses to wait after a point, legal range 1..15.
REQ-005 Port clk, input, 1 bit: rising-edge system clock.
REQ-006 Port reset, input, 1 bit: asynchronous active-low reset.
REQ-007 Port xPosition, input, 6 bits: ball column, 0..63.
REQ-008 Port yPosition, input, 5 bits: ball row, 0..31.
REQ-009 Port isBallMoving, input, 1 bit: one-cycle move tick from the ball block.
REQ-010 Port leftPaddleY, input, 5 bits: top row of the left paddle.
REQ-011 Port rightPaddleY, input, 5 bits: top row of the right paddle.
REQ-012 Port isHittingLeft, output, 1 bit: registered flag, ball is on the left paddle.
REQ-013 Port isHittingRight, output, 1 bit: registered flag, ball is on the right paddle.
REQ-014 Port leftScore, output, 4 bits: points won by the left player.
REQ-015 Port rightScore, output, 4 bits: points won by the right player.
REQ-016 Port pointScored, output, 1 bit: one-cycle pulse when a point is awarded.
REQ-017 Port serveRequest, output, 1 bit: one-cycle pulse when the HOLD state ends.
REQ-018 Port gameOver, output, 1 bit: high while in the OVER state.

Function
REQ-019 Paddle span: a paddle covers rows paddleY through paddleY+PADDLE_HEIGHT-1.
  - Compute the span in 6 bits so it never wraps.
  - Rows above 31 do not exist.
REQ-020 isHittingLeft SHALL be registered every cycle as 1 when xPosition<=1 and yPosition is inside the left span. Latency is one cycle and it is independent of the state.
REQ-021 isHittingRight SHALL be registered every cycle as 1 when xPosition>=62 and yPosition is inside the right span. Latency is one cycle.
REQ-022 The FSM SHALL have three states: PLAY, HOLD and OVER. Reset state is PLAY.
REQ-023 In PLAY, when a cycle has isBallMoving=1 and xPosition==0 and isHittingLeft=0, the block SHALL:
  - increment rightScore;
  - pulse pointScored;
  - go to HOLD.
REQ-024 In PLAY, when a cycle has isBallMoving=1 and xPosition==63 and isHittingRight=0, the block SHALL:
  - increment leftScore;
  - pulse pointScored;
  - go to HOLD.
REQ-025 Misses SHALL be evaluated only on isBallMoving cycles and only in PLAY. While in HOLD or OVER, a ball sitting at x=0 or x=63 awards no point.
REQ-026 HOLD SHALL count isBallMoving pulses with a 4-bit counter that is cleared on entry.
  - When the count reaches HOLD_TICKS, pulse serveRequest and go to PLAY.
  - The exception is a score equal to WIN_SCORE, which goes to OVER instead and does not pulse serveRequest.
REQ-027 Scores SHALL saturate at WIN_SCORE and never wrap.
REQ-028 In OVER, both scores SHALL hold, gameOver SHALL be 1, and the miss logic SHALL be inactive.

Reset
REQ-029 While reset is low, the block SHALL drive these values:
  - state = PLAY;
  - both scores = 0;
  - HOLD counter = 0;
  - isHittingLeft, isHittingRight, pointScored, serveRequest, gameOver = 0.
REQ-030 Reset asserted in any state, including mid-HOLD, SHALL abort immediately with no pending pulse. The first evaluation happens on the first clk edge after reset deasserts.

Configuration
REQ-031 Macro PONG_AUTO_RESTART_EN, when defined: OVER SHALL count HOLD_TICKS isBallMoving pulses, then clear both scores, pulse serveRequest and go to PLAY.
REQ-032 Macro PONG_AUTO_RESTART_EN, when undefined: OVER SHALL be left only by reset.

Verification
REQ-033 Left hit: leftPaddleY=3, x=1, y=5. isHittingLeft=1 one cycle later. With y=7, isHittingLeft=0.
REQ-034 Right hit at span edge: rightPaddleY=30, x=63, y=31, isBallMoving pulse. isHittingRight=1, no point, and leftScore stays 0.
REQ-035 Left miss: x=0, y=20, leftPaddleY=0, isBallMoving pulse. Then:
  - rightScore goes 0->1;
  - pointScored pulses for one cycle;
  - after 8 further pulses, serveRequest pulses once.
REQ-036 Win: rightScore=8, left miss. rightScore=9 and gameOver=1 with no serveRequest. A later x=63 miss leaves leftScore at 0.
REQ-037 Reset during HOLD after 3 ticks: scores=0, state PLAY, no serveRequest pulse.
REQ-038 PONG_AUTO_RESTART_EN defined, OVER reached: after 8 pulses, scores=0, serveRequest pulses, gameOver=0.

Source files
------------

// File: rtl/pong_referee.sv
// ---------------------------------------------------------------------------
// pong_referee
//
// Purpose: referee for a Pong playfield. It flags paddle contact every cycle,
// awards points when the ball reaches an edge column without a paddle
// behind it, pauses for a serve delay after each point and stops the game
// once a player reaches the winning score.
//
// Parameters:
//   PADDLE_HEIGHT  paddle length in rows (1..8)
//   WIN_SCORE      score that ends the game (1..15)
//   HOLD_TICKS     isBallMoving pulses to wait after a point (1..15)
//
// Ports:
//   clk             rising-edge system clock
//   reset           asynchronous active-low reset
//   xPosition[5:0]  ball column 0..63
//   yPosition[4:0]  ball row 0..31
//   isBallMoving    one-cycle move tick from the ball block
//   leftPaddleY     top row of the left paddle
//   rightPaddleY    top row of the right paddle
//   isHittingLeft   registered: ball is on the left paddle
//   isHittingRight  registered: ball is on the right paddle
//   leftScore       points won by the left player
//   rightScore      points won by the right player
//   pointScored     one-cycle pulse when a point is awarded
//   serveRequest    one-cycle pulse when the post-point pause ends
//   gameOver        high while the game is over
//
// Build option:
//   PONG_AUTO_RESTART_EN  when defined, the game-over state waits HOLD_TICKS
//                         move ticks, clears the scores and serves again.
//                         When undefined, only reset leaves game-over.
// ---------------------------------------------------------------------------
module pong_referee #(
    parameter int PADDLE_HEIGHT = 4,
    parameter int WIN_SCORE     = 9,
    parameter int HOLD_TICKS    = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] xPosition,
    input  logic [4:0] yPosition,
    input  logic       isBallMoving,
    input  logic [4:0] leftPaddleY,
    input  logic [4:0] rightPaddleY,
    output logic       isHittingLeft,
    output logic       isHittingRight,
    output logic [3:0] leftScore,
    output logic [3:0] rightScore,
    output logic       pointScored,
    output logic       serveRequest,
    output logic       gameOver
);

    localparam logic [5:0] SPAN_EXT = 6'(PADDLE_HEIGHT - 1);
    localparam logic [3:0] WIN_VAL  = 4'(WIN_SCORE);
    localparam logic [3:0] HOLD_VAL = 4'(HOLD_TICKS);

    typedef enum logic [1:0] {
        ST_PLAY = 2'd0,
        ST_HOLD = 2'd1,
        ST_OVER = 2'd2
    } state_t;

    state_t     state_q;
    logic [3:0] cnt_q;
    logic [3:0] left_score_q;
    logic [3:0] right_score_q;
    logic       hit_left_q;
    logic       hit_right_q;
    logic       point_q;
    logic       serve_q;
    logic       over_q;

    // Bottom row of each paddle is computed one bit wider so a paddle near
    // row 31 covers the rows down to 31 instead of wrapping back to row 0.
    logic [5:0] left_bottom;
    logic [5:0] right_bottom;
    logic       left_in_span;
    logic       right_in_span;
    logic [3:0] cnt_inc;

    always_comb begin
        left_bottom   = {1'b0, leftPaddleY} + SPAN_EXT;
        right_bottom  = {1'b0, rightPaddleY} + SPAN_EXT;
        left_in_span  = (yPosition >= leftPaddleY) &&
                        ({1'b0, yPosition} <= left_bottom);
        right_in_span = (yPosition >= rightPaddleY) &&
                        ({1'b0, yPosition} <= right_bottom);
        cnt_inc       = cnt_q + 4'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_PLAY;
            cnt_q         <= 4'd0;
            left_score_q  <= 4'd0;
            right_score_q <= 4'd0;
            hit_left_q    <= 1'b0;
            hit_right_q   <= 1'b0;
            point_q       <= 1'b0;
            serve_q       <= 1'b0;
            over_q        <= 1'b0;
        end else begin
            // Contact flags track the ball every cycle regardless of state.
            hit_left_q  <= (xPosition <= 6'd1)  && left_in_span;
            hit_right_q <= (xPosition >= 6'd62) && right_in_span;
            point_q     <= 1'b0;
            serve_q     <= 1'b0;

            case (state_q)
                ST_PLAY: begin
                    // Misses use the contact flag registered last cycle.
                    if (isBallMoving) begin
                        if ((xPosition == 6'd0) && !hit_left_q) begin
                            if (right_score_q < WIN_VAL)
                                right_score_q <= right_score_q + 4'd1;
                            point_q <= 1'b1;
                            cnt_q   <= 4'd0;
                            state_q <= ST_HOLD;
                        end else if ((xPosition == 6'd63) && !hit_right_q) begin
                            if (left_score_q < WIN_VAL)
                                left_score_q <= left_score_q + 4'd1;
                            point_q <= 1'b1;
                            cnt_q   <= 4'd0;
                            state_q <= ST_HOLD;
                        end
                    end
                end

                ST_HOLD: begin
                    if (isBallMoving) begin
                        if (cnt_inc == HOLD_VAL) begin
                            cnt_q <= 4'd0;
                            if ((left_score_q == WIN_VAL) ||
                                (right_score_q == WIN_VAL)) begin
                                state_q <= ST_OVER;
                                over_q  <= 1'b1;
                            end else begin
                                serve_q <= 1'b1;
                                state_q <= ST_PLAY;
                            end
                        end else begin
                            cnt_q <= cnt_inc;
                        end
                    end
                end

                ST_OVER: begin
`ifdef PONG_AUTO_RESTART_EN
                    if (isBallMoving) begin
                        if (cnt_inc == HOLD_VAL) begin
                            cnt_q         <= 4'd0;
                            left_score_q  <= 4'd0;
                            right_score_q <= 4'd0;
                            serve_q       <= 1'b1;
                            over_q        <= 1'b0;
                            state_q       <= ST_PLAY;
                        end else begin
                            cnt_q <= cnt_inc;
                        end
                    end
`else
                    // Scores frozen; only reset leaves this state.
                    over_q <= 1'b1;
`endif
                end

                default: begin
                    state_q <= ST_PLAY;
                    over_q  <= 1'b0;
                end
            endcase
        end
    end

    assign isHittingLeft  = hit_left_q;
    assign isHittingRight = hit_right_q;
    assign leftScore      = left_score_q;
    assign rightScore     = right_score_q;
    assign pointScored    = point_q;
    assign serveRequest   = serve_q;
    assign gameOver       = over_q;

endmodule

// File: tb/tb_pong_referee.sv
// ---------------------------------------------------------------------------
// tb_pong_referee: table of paddle-contact vectors, hand-written sequences for
// hit, miss, serve delay, win, reset-in-pause and game-over behaviour, then
// randomized play checked against a behavioural game model.
// ---------------------------------------------------------------------------
module tb_pong_referee;

    localparam int PH   = 4;
    localparam int WIN  = 9;
    localparam int HOLD = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [5:0] xPosition = '0;
    logic [4:0] yPosition = '0;
    logic       isBallMoving = 1'b0;
    logic [4:0] leftPaddleY = '0;
    logic [4:0] rightPaddleY = '0;
    logic       isHittingLeft, isHittingRight;
    logic [3:0] leftScore, rightScore;
    logic       pointScored, serveRequest, gameOver;

    pong_referee #(.PADDLE_HEIGHT(PH), .WIN_SCORE(WIN), .HOLD_TICKS(HOLD)) dut (
        .clk(clk), .reset(reset),
        .xPosition(xPosition), .yPosition(yPosition),
        .isBallMoving(isBallMoving),
        .leftPaddleY(leftPaddleY), .rightPaddleY(rightPaddleY),
        .isHittingLeft(isHittingLeft), .isHittingRight(isHittingRight),
        .leftScore(leftScore), .rightScore(rightScore),
        .pointScored(pointScored), .serveRequest(serveRequest),
        .gameOver(gameOver)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // ---------------- behavioural game model ----------------
    // phase: "play", "pause" (after a point), "over"
    string m_phase = "play";
    int    m_ticks = 0;
    int    m_ls = 0, m_rs = 0;
    bit    m_hl = 0, m_hr = 0, m_point = 0, m_serve = 0;

    function automatic bit on_paddle(int y, int top);
        return (y >= top) && (y < top + PH);
    endfunction

    function automatic int sat_inc(int s);
        return (s + 1 > WIN) ? WIN : s + 1;
    endfunction

    function automatic void model_reset();
        m_phase = "play"; m_ticks = 0; m_ls = 0; m_rs = 0;
        m_hl = 0; m_hr = 0; m_point = 0; m_serve = 0;
    endfunction

    // Advance the model by one clock edge using the currently driven inputs.
    function automatic void model_edge();
        int  x, y;
        bit  was_hl, was_hr;
        x = int'(xPosition); y = int'(yPosition);
        was_hl = m_hl; was_hr = m_hr;
        m_hl = (x <= 1)  && on_paddle(y, int'(leftPaddleY));
        m_hr = (x >= 62) && on_paddle(y, int'(rightPaddleY));
        m_point = 0; m_serve = 0;
        if (!isBallMoving) return;
        if (m_phase == "play") begin
            if (x == 0 && !was_hl) begin
                m_rs = sat_inc(m_rs); m_point = 1; m_phase = "pause"; m_ticks = 0;
            end else if (x == 63 && !was_hr) begin
                m_ls = sat_inc(m_ls); m_point = 1; m_phase = "pause"; m_ticks = 0;
            end
        end else if (m_phase == "pause") begin
            m_ticks++;
            if (m_ticks == HOLD) begin
                m_ticks = 0;
                if (m_ls == WIN || m_rs == WIN) m_phase = "over";
                else begin m_serve = 1; m_phase = "play"; end
            end
        end else begin
`ifdef PONG_AUTO_RESTART_EN
            m_ticks++;
            if (m_ticks == HOLD) begin
                m_ticks = 0; m_ls = 0; m_rs = 0; m_serve = 1; m_phase = "play";
            end
`endif
        end
    endfunction

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".isHittingLeft"},  int'(isHittingLeft),  int'(m_hl));
        chk({tag, ".isHittingRight"}, int'(isHittingRight), int'(m_hr));
        chk({tag, ".leftScore"},      int'(leftScore),      m_ls);
        chk({tag, ".rightScore"},     int'(rightScore),     m_rs);
        chk({tag, ".pointScored"},    int'(pointScored),    int'(m_point));
        chk({tag, ".serveRequest"},   int'(serveRequest),   int'(m_serve));
        chk({tag, ".gameOver"},       int'(gameOver),       int'(m_phase == "over"));
    endtask

    // One clock: drive inputs, take the edge, sample 1 ns later.
    task automatic cycle(input int x, input int y, input bit mv,
                         input int lp, input int rp, input string tag);
        xPosition = 6'(x); yPosition = 5'(y); isBallMoving = mv;
        leftPaddleY = 5'(lp); rightPaddleY = 5'(rp);
        @(posedge clk);
        model_edge();
        #1;
        check_model(tag);
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b0;
        model_reset();
        #1;
        chk({tag, ".rst_left"},  int'(leftScore),  0);
        chk({tag, ".rst_right"}, int'(rightScore), 0);
        chk({tag, ".rst_flags"},
            int'({isHittingLeft, isHittingRight, pointScored, serveRequest, gameOver}), 0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    // Award one right-player point by a left miss followed by the pause.
    task automatic left_miss_and_pause(input string tag);
        cycle(0, 20, 0, 0, 0, tag);
        cycle(0, 20, 1, 0, 0, tag);
        for (int k = 0; k < HOLD; k++) cycle(32, 10, 1, 0, 0, tag);
    endtask

    typedef struct {
        int x, y, lp, rp;
        bit hl, hr;
    } hit_vec_t;

    hit_vec_t vecs [$];

    initial begin
        // {x, y, leftPaddleY, rightPaddleY, expect left hit, expect right hit}
        vecs.push_back('{1,  5,  3,  0, 1, 0});
        vecs.push_back('{1,  7,  3,  0, 0, 0});
        vecs.push_back('{0,  3,  3,  0, 1, 0});
        vecs.push_back('{0,  6,  3,  0, 1, 0});
        vecs.push_back('{0,  2,  3,  0, 0, 0});
        vecs.push_back('{2,  5,  3,  0, 0, 0});
        vecs.push_back('{1, 31, 30,  0, 1, 0});
        vecs.push_back('{1,  0, 30,  0, 0, 0});
        vecs.push_back('{63, 31, 0, 30, 0, 1});
        vecs.push_back('{62, 13, 0, 10, 0, 1});
        vecs.push_back('{62, 14, 0, 10, 0, 0});
        vecs.push_back('{61, 10, 0, 10, 0, 0});
        vecs.push_back('{63,  9, 0, 10, 0, 0});

        do_reset("init");
        $display("reset: scores %0d/%0d gameOver=%0d", leftScore, rightScore, gameOver);

        // Table: contact flags with no move tick, so no scoring happens.
        foreach (vecs[i]) begin
            cycle(vecs[i].x, vecs[i].y, 0, vecs[i].lp, vecs[i].rp, "tbl");
            chk($sformatf("tbl[%0d].hitL", i), int'(isHittingLeft),  int'(vecs[i].hl));
            chk($sformatf("tbl[%0d].hitR", i), int'(isHittingRight), int'(vecs[i].hr));
            $display("vec %0d: x=%0d y=%0d lp=%0d rp=%0d -> hitL=%0d hitR=%0d",
                     i, vecs[i].x, vecs[i].y, vecs[i].lp, vecs[i].rp,
                     isHittingLeft, isHittingRight);
        end

        // Right paddle at the bottom edge returns the ball: no point.
        cycle(63, 31, 0, 0, 30, "rhit");
        cycle(63, 31, 1, 0, 30, "rhit");
        chk("rhit.flag",  int'(isHittingRight), 1);
        chk("rhit.point", int'(pointScored), 0);
        chk("rhit.left",  int'(leftScore), 0);
        $display("right edge hit: hitR=%0d leftScore=%0d", isHittingRight, leftScore);

        // Left miss, one-cycle point pulse, serve after exactly HOLD ticks.
        cycle(0, 20, 0, 0, 0, "miss");
        cycle(0, 20, 1, 0, 0, "miss");
        chk("miss.right", int'(rightScore), 1);
        chk("miss.point", int'(pointScored), 1);
        cycle(0, 20, 0, 0, 0, "miss");
        chk("miss.point_end", int'(pointScored), 0);
        for (int k = 1; k <= HOLD; k++) begin
            cycle(0, 20, 1, 0, 0, "pause");
            chk($sformatf("pause.serve%0d", k), int'(serveRequest), int'(k == HOLD));
            chk($sformatf("pause.score%0d", k), int'(rightScore), 1);
        end
        cycle(32, 10, 0, 0, 0, "serve");
        chk("serve.end", int'(serveRequest), 0);
        $display("left miss: rightScore=%0d serve done", rightScore);

        // Raise right player to 8, then the winning miss.
        for (int p = 2; p <= WIN - 1; p++) left_miss_and_pause("climb");
        chk("climb.right", int'(rightScore), WIN - 1);
        cycle(0, 20, 0, 0, 0, "win");
        cycle(0, 20, 1, 0, 0, "win");
        chk("win.right", int'(rightScore), WIN);
        for (int k = 1; k <= HOLD; k++) begin
            cycle(32, 10, 1, 0, 0, "win_pause");
            chk($sformatf("win.noserve%0d", k), int'(serveRequest), 0);
        end
        chk("win.over", int'(gameOver), 1);
        cycle(63, 10, 0, 0, 0, "over");
        cycle(63, 10, 1, 0, 0, "over");
        chk("over.left", int'(leftScore), 0);
        chk("over.point", int'(pointScored), 0);
        $display("win: rightScore=%0d gameOver=%0d", rightScore, gameOver);
`ifdef PONG_AUTO_RESTART_EN
        for (int k = 2; k <= HOLD; k++) cycle(63, 10, 1, 0, 0, "restart");
        chk("restart.serve", int'(serveRequest), 1);
        chk("restart.over",  int'(gameOver), 0);
        chk("restart.score", int'({leftScore, rightScore}), 0);
        $display("auto restart: gameOver=%0d", gameOver);
`else
        for (int k = 0; k < 2 * HOLD; k++) cycle(0, 20, 1, 0, 0, "stuck");
        chk("stuck.over",  int'(gameOver), 1);
        chk("stuck.right", int'(rightScore), WIN);
        $display("game over holds: gameOver=%0d", gameOver);
`endif

        // Reset in the middle of a pause.
        do_reset("r2");
        cycle(0, 20, 0, 0, 0, "midhold");
        cycle(0, 20, 1, 0, 0, "midhold");
        for (int k = 0; k < 3; k++) cycle(32, 10, 1, 0, 0, "midhold");
        do_reset("midhold");
        for (int k = 0; k < HOLD + 2; k++) begin
            cycle(32, 10, 1, 0, 0, "after_rst");
            chk($sformatf("after_rst.serve%0d", k), int'(serveRequest), 0);
        end
        chk("after_rst.right", int'(rightScore), 0);
        $display("reset mid-pause: score=%0d serve stayed low", rightScore);

        // Randomized play against the model.
        for (int i = 0; i < 4000; i++) begin
            int x, sel;
            if ($urandom_range(0, 699) == 0) begin
                do_reset("rnd");
                continue;
            end
            sel = int'($urandom_range(0, 3));
            x = (sel == 0) ? 0 : (sel == 1) ? 63 : int'($urandom_range(0, 63));
            cycle(x, int'($urandom_range(0, 31)), ($urandom_range(0, 2) == 0),
                  int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), "rnd");
        end
        $display("random play done: scores %0d/%0d", leftScore, rightScore);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
